pyrxaclbufring: RTL and testbench
=================================

// Module: pyrxaclbufring
// PURPOSE
//  N-bank ring of ACL RX payload buffers between the link controller (write side) and the
//  baseband state machine / host reader (bsm, read side). Generalises two-bank ping-pong to
//  NBANK banks, adding a committed-packet count, full/overflow reporting, flush and length readback.
//  Link controller fills bank wp; a good data packet commits it; bsm drains banks in order from rp.
// PARAMETERS
//  NBANK  4   number of banks, 2..8; need not be a power of two
//  AW     8   word address width per bank (2**AW words; one sram256x32_1p per bank when AW=8, DW=32)
//  DW     32  data word width; 32 or 64; BPW=DW/8 bytes per word
//  LENW   10  payload length width in bytes
// PORTS
//  clk_6M            in   1        clock
//  rstz              in   1        reset, asynchronous, active-low
//  ms_tslot_p        in   1        slot-boundary pulse; commit qualifier
//  pk_encode         in   1        1=TX slot; blocks commit
//  dec_hecgood       in   1        header HEC ok
//  dec_crcgood       in   1        payload CRC ok
//  pktype_data       in   1        packet carries ACL data
//  dec_pylenByte     in   LENW     decoded payload length, bytes
//  lnctrl_addr       in   AW       write word address into bank wp
//  lnctrl_din        in   DW       write data
//  lnctrl_we         in   1        write strobe (also chip select)
//  bsm_addr          in   AW       read word address into bank rp
//  bsm_cs            in   1        read chip select
//  bsm_valid_p       in   1        pulse: bsm has consumed word at bsm_addr
//  regi_flush        in   1        sync pulse: discard all buffered packets
//  bsm_dout          out  DW       read data, bank rp_d
//  bsm_rxlenByte     out  LENW     length of bank rp (0 when empty)
//  regi_aclrxbufempty out 1        no committed packet
//  regi_aclrxbuffull out  1        count==NBANK
//  rxbuf_ovf_p       out  1        pulse: good packet dropped because full
//  rxbuf_count       out  $clog2(NBANK+1)  committed unread packets
// BEHAVIOUR
//  Reset: wp=rp=rp_d=0, count=0, all len[i]=0; empty=1, full=0, ovf_p=0, bsm_rxlenByte=0;
//   bsm_dout = registered SRAM output of bank 0 (don't-care contents).
//  commit = ms_tslot_p & !pk_encode & dec_hecgood & dec_crcgood & pktype_data.
//  release = bsm_valid_p & !empty & (bsm_addr >= endaddr), endaddr from len[rp]:
//   words = ceil(len/BPW); endaddr = words-1; len==0 -> endaddr=0 (one valid_p releases).
//  Write side: lnctrl_we reaches bank wp only when !full; when full writes are discarded.
//  Read side: bank rp CS = bsm_cs & !empty; WE=0. SRAM read latency 1 cycle; rp_d = rp
//   delayed 1 cycle selects bsm_dout so the last word of a bank is returned after rp moves.
//  On commit & !full: len[wp]<=dec_pylenByte; wp<=wp+1 (wrap NBANK-1->0); count+1.
//  On commit & full: no state change; rxbuf_ovf_p=1 for that cycle (registered, 1 cycle later).
//  On release: rp<=rp+1 (wrap), count-1; len[rp] kept (not cleared).
//  Commit & release same cycle: both pointers advance, count unchanged; a commit while
//   full with simultaneous release is accepted (release frees a bank first), no ovf.
//  regi_flush: highest priority; wp=rp=0, count=0, len[]=0; ovf not raised; concurrent
//   commit/release ignored. SRAM contents not cleared.
//  Pointers only ever meet with count in {0,NBANK}; count never exceeds NBANK or underflows.
//  Flags combinational from count: empty=(count==0), full=(count==NBANK).
//  Async reset mid-packet: partial bank abandoned, state as reset.
// TESTING
//  T1 reset, write 16 words to bank0, commit len=64 -> count=1, empty=0, bsm_rxlenByte=64;
//   read addr 0..15 with valid_p -> release on addr15, rp=1, empty=1, data matches.
//  T2 len=5 (BPW=4) -> endaddr=1; release after addr1; len=0 -> release on first valid_p.
//  T3 commit 4 packets (NBANK=4) -> full=1; 5th good packet -> ovf_p one cycle, count stays 4,
//   lnctrl writes ignored (bank0 data intact on readback).
//  T4 full, commit and release same cycle -> no ovf, count=4, wp and rp both advance, wrap to 0 ok.
//  T5 bad CRC / pk_encode=1 / pktype_data=0 at ms_tslot_p -> no commit, count unchanged.
//  T6 count=3, regi_flush coincident with commit -> count=0, wp=rp=0, empty=1, lens 0.

Source files
------------

// File: rtl/pyrxaclbufring.sv
// N-bank ring of ACL RX payload buffers: the link controller fills bank wp, a good data
// packet commits it, and the bsm drains committed banks in order from rp.
module pyrxaclbufring #(
    parameter int NBANK = 4,
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int LENW  = 10
) (
    input  logic                         clk_6M,
    input  logic                         rstz,
    input  logic                         ms_tslot_p,
    input  logic                         pk_encode,
    input  logic                         dec_hecgood,
    input  logic                         dec_crcgood,
    input  logic                         pktype_data,
    input  logic [LENW-1:0]              dec_pylenByte,
    input  logic [AW-1:0]                lnctrl_addr,
    input  logic [DW-1:0]                lnctrl_din,
    input  logic                         lnctrl_we,
    input  logic [AW-1:0]                bsm_addr,
    input  logic                         bsm_cs,
    input  logic                         bsm_valid_p,
    input  logic                         regi_flush,
    output logic [DW-1:0]                bsm_dout,
    output logic [LENW-1:0]              bsm_rxlenByte,
    output logic                         regi_aclrxbufempty,
    output logic                         regi_aclrxbuffull,
    output logic                         rxbuf_ovf_p,
    output logic [$clog2(NBANK+1)-1:0]   rxbuf_count
);

    localparam int PW    = $clog2(NBANK);
    localparam int CNW   = $clog2(NBANK + 1);
    localparam int BSH   = $clog2(DW / 8);
    localparam int CW    = (AW > LENW) ? AW : LENW;
    localparam int DEPTH = 1 << AW;

    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d, rp_dly_q;
    logic [CNW-1:0]  count_q, count_d;
    logic [LENW-1:0] len_q [NBANK];
    logic [LENW-1:0] len_d [NBANK];
    logic            ovf_q, ovf_d;

    logic [DW-1:0]   mem [NBANK][DEPTH];
    logic [DW-1:0]   rdata_q [NBANK];

    logic            empty, full, commit, rel, accept;
    logic [LENW-1:0] cur_len, end_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NBANK - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNW'(NBANK));
    assign commit   = ms_tslot_p & ~pk_encode & dec_hecgood & dec_crcgood & pktype_data;
    assign cur_len  = len_q[rp_q];
    // Last word index is ceil(len/BPW)-1; a zero-length packet still ends at word 0.
    assign end_addr = (cur_len == '0) ? '0 : (cur_len - LENW'(1)) >> BSH;
    assign rel      = bsm_valid_p & ~empty & (CW'(bsm_addr) >= CW'(end_addr));
    // A release in the same cycle frees a bank, so a commit while full is still taken.
    assign accept   = commit & (~full | rel);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = 1'b0;
        if (regi_flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            for (int i = 0; i < NBANK; i++) len_d[i] = '0;
        end else begin
            ovf_d = commit & full & ~rel;
            if (accept) begin
                len_d[wp_q] = dec_pylenByte;
                wp_d        = ptr_inc(wp_q);
            end
            if (rel) rp_d = ptr_inc(rp_q);
            count_d = count_q + CNW'(accept) - CNW'(rel);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            wp_q     <= '0;
            rp_q     <= '0;
            rp_dly_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NBANK; i++) len_q[i] <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            rp_dly_q <= rp_q;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            len_q    <= len_d;
        end
    end

    // NOTE: the bank arrays and their read registers are SRAM macros and carry no reset.
    always_ff @(posedge clk_6M) begin
        if (lnctrl_we && !full) mem[wp_q][lnctrl_addr] <= lnctrl_din;
        for (int b = 0; b < NBANK; b++) begin
            if (bsm_cs && !empty && (rp_q == PW'(b))) rdata_q[b] <= mem[b][bsm_addr];
        end
    end

    // rp_dly_q keeps the bank that produced the last read selected after rp has moved on.
    assign bsm_dout           = rdata_q[rp_dly_q];
    assign bsm_rxlenByte      = empty ? '0 : cur_len;
    assign regi_aclrxbufempty = empty;
    assign regi_aclrxbuffull  = full;
    assign rxbuf_ovf_p        = ovf_q;
    assign rxbuf_count        = count_q;

endmodule

// File: tb/tb_pyrxaclbufring.sv
// Bench for pyrxaclbufring: a packet-queue reference model checked every cycle, a commit
// qualifier table, hand-written corner sequences and a randomized soak.
module tb_pyrxaclbufring;

    localparam int NBANK = 4;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LENW  = 10;
    localparam int BPW   = DW / 8;
    localparam int CNW   = $clog2(NBANK + 1);

    logic            clk_6M = 1'b0;
    logic            rstz = 1'b0;
    logic            ms_tslot_p = 0, pk_encode = 0, dec_hecgood = 0, dec_crcgood = 0, pktype_data = 0;
    logic [LENW-1:0] dec_pylenByte = '0;
    logic [AW-1:0]   lnctrl_addr = '0;
    logic [DW-1:0]   lnctrl_din = '0;
    logic            lnctrl_we = 0;
    logic [AW-1:0]   bsm_addr = '0;
    logic            bsm_cs = 0, bsm_valid_p = 0, regi_flush = 0;
    logic [DW-1:0]   bsm_dout;
    logic [LENW-1:0] bsm_rxlenByte;
    logic            regi_aclrxbufempty, regi_aclrxbuffull, rxbuf_ovf_p;
    logic [CNW-1:0]  rxbuf_count;

    always #5 clk_6M = ~clk_6M;

    pyrxaclbufring #(.NBANK(NBANK), .AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk_6M(clk_6M), .rstz(rstz),
        .ms_tslot_p(ms_tslot_p), .pk_encode(pk_encode), .dec_hecgood(dec_hecgood),
        .dec_crcgood(dec_crcgood), .pktype_data(pktype_data), .dec_pylenByte(dec_pylenByte),
        .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din), .lnctrl_we(lnctrl_we),
        .bsm_addr(bsm_addr), .bsm_cs(bsm_cs), .bsm_valid_p(bsm_valid_p), .regi_flush(regi_flush),
        .bsm_dout(bsm_dout), .bsm_rxlenByte(bsm_rxlenByte),
        .regi_aclrxbufempty(regi_aclrxbufempty), .regi_aclrxbuffull(regi_aclrxbuffull),
        .rxbuf_ovf_p(rxbuf_ovf_p), .rxbuf_count(rxbuf_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed packets as a FIFO of (length, bank), plus a shadow of bank contents.
    int            q_len[$];
    int            q_bank[$];
    int            m_wp;
    logic [DW-1:0] m_mem [NBANK][256];
    bit            m_wr  [NBANK][256];
    bit            exp_ovf;
    bit            dout_chk;
    logic [DW-1:0] exp_dout;

    typedef struct {
        bit tslot, enc, hec, crc, data;
        int len;
        int exp_count;
        bit exp_full;
        bit exp_ovf;
        int exp_rxlen;
    } vec_t;

    function automatic int last_word(int len);
        if (len == 0) return 0;
        return (len + BPW - 1) / BPW - 1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_len.delete();
        q_bank.delete();
        m_wp     = 0;
        exp_ovf  = 0;
        dout_chk = 0;
    endtask

    task automatic check_outputs();
        check("count", 64'(rxbuf_count), 64'(q_len.size()));
        check("empty", 64'(regi_aclrxbufempty), 64'(q_len.size() == 0));
        check("full", 64'(regi_aclrxbuffull), 64'(q_len.size() == NBANK));
        check("ovf", 64'(rxbuf_ovf_p), 64'(exp_ovf));
        check("rxlen", 64'(bsm_rxlenByte), 64'((q_len.size() == 0) ? 0 : q_len[0]));
        if (dout_chk) check("dout", 64'(bsm_dout), 64'(exp_dout));
    endtask

    // One clock: update the model from the current inputs, advance, compare everything.
    task automatic tick();
        bit com, rel, full_b;
        full_b = (q_len.size() == NBANK);
        com    = ms_tslot_p && !pk_encode && dec_hecgood && dec_crcgood && pktype_data;
        rel    = bsm_valid_p && (q_len.size() > 0) && (int'(bsm_addr) >= last_word(q_len[0]));
        dout_chk = 0;
        if (bsm_cs && q_len.size() > 0 && m_wr[q_bank[0]][bsm_addr]) begin
            dout_chk = 1;
            exp_dout = m_mem[q_bank[0]][bsm_addr];
        end
        if (lnctrl_we && !full_b) begin
            m_mem[m_wp][lnctrl_addr] = lnctrl_din;
            m_wr[m_wp][lnctrl_addr]  = 1;
        end
        if (regi_flush) begin
            q_len.delete();
            q_bank.delete();
            m_wp    = 0;
            exp_ovf = 0;
        end else begin
            exp_ovf = com && full_b && !rel;
            if (rel) begin
                void'(q_len.pop_front());
                void'(q_bank.pop_front());
            end
            if (com && (!full_b || rel)) begin
                q_len.push_back(int'(dec_pylenByte));
                q_bank.push_back(m_wp);
                m_wp = (m_wp + 1) % NBANK;
            end
        end
        @(posedge clk_6M);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        ms_tslot_p = 0; pk_encode = 0; dec_hecgood = 0; dec_crcgood = 0; pktype_data = 0;
        lnctrl_we = 0; bsm_cs = 0; bsm_valid_p = 0; regi_flush = 0;
    endtask

    task automatic good_commit(input int len);
        ms_tslot_p = 1; pk_encode = 0; dec_hecgood = 1; dec_crcgood = 1; pktype_data = 1;
        dec_pylenByte = LENW'(len);
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] d);
        idle_inputs();
        lnctrl_we = 1; lnctrl_addr = AW'(addr); lnctrl_din = d;
        tick();
        lnctrl_we = 0;
    endtask

    task automatic read_word(input int addr, input bit valid);
        idle_inputs();
        bsm_cs = 1; bsm_valid_p = valid; bsm_addr = AW'(addr);
        tick();
        bsm_cs = 0; bsm_valid_p = 0;
    endtask

    vec_t vecs[11];

    initial begin
        for (int b = 0; b < NBANK; b++)
            for (int a = 0; a < 256; a++) m_wr[b][a] = 0;
        model_reset();

        vecs[0]  = '{1, 0, 1, 1, 1,  12, 1, 0, 0, 12};
        vecs[1]  = '{1, 1, 1, 1, 1,  40, 1, 0, 0, 12};
        vecs[2]  = '{1, 0, 0, 1, 1,  40, 1, 0, 0, 12};
        vecs[3]  = '{1, 0, 1, 0, 1,  40, 1, 0, 0, 12};
        vecs[4]  = '{1, 0, 1, 1, 0,  40, 1, 0, 0, 12};
        vecs[5]  = '{0, 0, 1, 1, 1,  40, 1, 0, 0, 12};
        vecs[6]  = '{1, 0, 1, 1, 1,   7, 2, 0, 0, 12};
        vecs[7]  = '{1, 0, 1, 1, 1,   0, 3, 0, 0, 12};
        vecs[8]  = '{1, 0, 1, 1, 1, 100, 4, 1, 0, 12};
        vecs[9]  = '{1, 0, 1, 1, 1,  33, 4, 1, 1, 12};
        vecs[10] = '{0, 0, 1, 1, 1,  33, 4, 1, 0, 12};

        // Reset state
        repeat (2) @(posedge clk_6M);
        #1;
        check("rst_count", 64'(rxbuf_count), 64'(0));
        check("rst_empty", 64'(regi_aclrxbufempty), 64'(1));
        check("rst_full", 64'(regi_aclrxbuffull), 64'(0));
        check("rst_ovf", 64'(rxbuf_ovf_p), 64'(0));
        check("rst_rxlen", 64'(bsm_rxlenByte), 64'(0));
        rstz = 1;

        // T1: 16 words into bank 0, len 64, drain with release on word 15
        for (int a = 0; a < 16; a++) write_word(a, 32'hA500_0000 | DW'(a));
        idle_inputs(); good_commit(64); tick();
        check("t1_count", 64'(rxbuf_count), 64'(1));
        check("t1_len", 64'(bsm_rxlenByte), 64'(64));
        for (int a = 0; a < 16; a++) begin
            read_word(a, 1);
            check("t1_data", 64'(bsm_dout), 64'(32'hA500_0000 | DW'(a)));
            if (a == 14) check("t1_hold", 64'(rxbuf_count), 64'(1));
        end
        check("t1_released", 64'(regi_aclrxbufempty), 64'(1));

        // T2: len 5 ends at word 1; len 0 releases on the first valid pulse
        write_word(0, 32'hB200_0000);
        write_word(1, 32'hB200_0001);
        idle_inputs(); good_commit(5); tick();
        read_word(0, 1);
        check("t2_len5_hold", 64'(rxbuf_count), 64'(1));
        read_word(1, 1);
        check("t2_len5_rel", 64'(rxbuf_count), 64'(0));
        check("t2_lastword", 64'(bsm_dout), 64'(32'hB200_0001));
        idle_inputs(); good_commit(0); tick();
        check("t2_len0_len", 64'(bsm_rxlenByte), 64'(0));
        check("t2_len0_cnt", 64'(rxbuf_count), 64'(1));
        read_word(0, 1);
        check("t2_len0_rel", 64'(rxbuf_count), 64'(0));

        // Flush back to bank 0 and seed known data there
        idle_inputs(); regi_flush = 1; tick();
        for (int a = 0; a < 4; a++) write_word(a, 32'hC0DE_0000 | DW'(a));

        // Commit qualifier table, filling to full and overflowing (T3, T5)
        foreach (vecs[i]) begin
            idle_inputs();
            ms_tslot_p = vecs[i].tslot; pk_encode = vecs[i].enc; dec_hecgood = vecs[i].hec;
            dec_crcgood = vecs[i].crc; pktype_data = vecs[i].data;
            dec_pylenByte = LENW'(vecs[i].len);
            tick();
            check($sformatf("tbl%0d_count", i), 64'(rxbuf_count), 64'(vecs[i].exp_count));
            check($sformatf("tbl%0d_full", i), 64'(regi_aclrxbuffull), 64'(vecs[i].exp_full));
            check($sformatf("tbl%0d_ovf", i), 64'(rxbuf_ovf_p), 64'(vecs[i].exp_ovf));
            check($sformatf("tbl%0d_rxlen", i), 64'(bsm_rxlenByte), 64'(vecs[i].exp_rxlen));
        end

        // T3: writes while full are dropped; bank 0 keeps its data
        write_word(0, 32'hDEAD_BEEF);
        read_word(0, 0);
        check("t3_intact", 64'(bsm_dout), 64'(32'hC0DE_0000));

        // T4: full with commit and release together, four times to wrap both pointers
        for (int k = 0; k < NBANK; k++) begin
            idle_inputs(); good_commit(20 + k);
            bsm_valid_p = 1; bsm_addr = AW'(255);
            tick();
            check("t4_count", 64'(rxbuf_count), 64'(NBANK));
            check("t4_ovf", 64'(rxbuf_ovf_p), 64'(0));
        end
        check("t4_wrap_len", 64'(bsm_rxlenByte), 64'(20));

        // T6: count 3, flush coincident with a commit
        read_word(255, 1);
        check("t6_pre", 64'(rxbuf_count), 64'(3));
        idle_inputs(); good_commit(50); regi_flush = 1; tick();
        check("t6_count", 64'(rxbuf_count), 64'(0));
        check("t6_empty", 64'(regi_aclrxbufempty), 64'(1));
        check("t6_rxlen", 64'(bsm_rxlenByte), 64'(0));
        idle_inputs(); good_commit(9); tick();
        read_word(0, 0);
        check("t6_bank0", 64'(bsm_dout), 64'(32'hC0DE_0000));

        // Async reset in the middle of filling a bank
        write_word(5, 32'h1234_5678);
        idle_inputs(); good_commit(16); tick();
        #2 rstz = 0;
        #1;
        model_reset();
        check("arst_count", 64'(rxbuf_count), 64'(0));
        check("arst_empty", 64'(regi_aclrxbufempty), 64'(1));
        check("arst_rxlen", 64'(bsm_rxlenByte), 64'(0));
        #1 rstz = 1;

        // Randomized soak against the queue model
        for (int n = 0; n < 3000; n++) begin
            ms_tslot_p    = ($urandom_range(0, 99) < 35);
            pk_encode     = ($urandom_range(0, 99) < 10);
            dec_hecgood   = ($urandom_range(0, 99) < 90);
            dec_crcgood   = ($urandom_range(0, 99) < 85);
            pktype_data   = ($urandom_range(0, 99) < 90);
            dec_pylenByte = LENW'($urandom_range(0, 1023));
            lnctrl_we     = $urandom_range(0, 1);
            lnctrl_addr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 255));
            lnctrl_din    = $urandom;
            bsm_cs        = ($urandom_range(0, 99) < 60);
            bsm_valid_p   = ($urandom_range(0, 99) < 30);
            bsm_addr      = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 255));
            regi_flush    = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
